prio_encoder_queue: RTL

// - Parametrised successor to the 3-bit enabled encoder: N request lines latched into a pending

---
 rtl/enc_pkg.sv | 25 ++
 rtl/prio_scan.sv | 38 +++
 rtl/prio_encoder_queue.sv | 90 +++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and width helpers for the request priority encoder queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package enc_pkg;

  // Selection policy codes for the RR parameter of prio_encoder_queue
  localparam int ENC_MODE_FIXED = 0;
  localparam int ENC_MODE_RR    = 1;

  // Default geometry: eight request lines
  localparam int ENC_N_DEF    = 8;
  localparam int ENC_IDXW_DEF = $clog2(ENC_N_DEF);
  localparam int ENC_CNTW_DEF = $clog2(ENC_N_DEF + 1);

  // Width of a binary index into n lines (at least one bit)
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold a population count of 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prio_scan.sv
// Rotated priority search: first set bit of mask, starting at start and descending with wrap.
// Latency: purely combinational.
// Backpressure: none; evaluated continuously from its inputs.
module prio_scan
  import enc_pkg::*;
#(
  parameter int N    = ENC_N_DEF,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    mask,
  input  logic [IDXW-1:0] start,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  // Position reached after stepping k places down from s, wrapping below 0 to N-1
  function automatic logic [IDXW-1:0] wrap_sub(input logic [IDXW-1:0] s, input int k);
    int p;
    p = int'(s) - k;
    if (p < 0) begin
      p = p + N;
    end
    return IDXW'(p);
  endfunction

  // Walk from the farthest position towards start so the closest set bit overwrites last
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[wrap_sub(start, k)]) begin
        idx   = wrap_sub(start, k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_queue.sv
// Latches N request lines into a pending mask and hands out one binary index per accepted transfer.
// Latency: req sampled at edge t is visible on out_idx in cycle t+1; out_* are combinational from registers.
// Backpressure: out_valid/out_ready; an unaccepted index stays pending, repeat requests merge and pulse overflow.
module prio_encoder_queue
  import enc_pkg::*;
#(
  parameter int N    = ENC_N_DEF,
  parameter int IDXW = idx_width(N),
  parameter int CNTW = cnt_width(N),
  parameter int RR   = ENC_MODE_FIXED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N-1:0]    req,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    pending,
  output logic [CNTW-1:0] pend_cnt,
  output logic            overflow
);

  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] scan_start;
  logic [IDXW-1:0] scan_idx;
  logic            scan_found;
  logic            xfer;
  logic [N-1:0]    grant_oh;
  logic [N-1:0]    pend_nxt;

  // Number of set bits in a request mask
  function automatic logic [CNTW-1:0] popcnt(input logic [N-1:0] m);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CNTW'(m[i]);
    end
    return c;
  endfunction

  // Fixed priority is a rotated search that always starts at the top index
  assign scan_start = (RR == ENC_MODE_RR) ? ptr : TOP_IDX;

  prio_scan #(
    .N    (N),
    .IDXW (IDXW)
  ) u_scan (
    .mask  (pending),
    .start (scan_start),
    .idx   (scan_idx),
    .found (scan_found)
  );

  // Output side sees only registered state and enable, never req or out_ready
  assign out_valid = enable & scan_found;
  assign out_idx   = out_valid ? scan_idx : '0;
  assign xfer      = out_valid & out_ready;

  // One-hot of the index being handed over this cycle
  always_comb begin
    grant_oh = '0;
    if (xfer) begin
      grant_oh[out_idx] = 1'b1;
    end
  end

  // A fresh request on the granted bit re-arms it because req is ORed after the clear
  assign pend_nxt = enable ? ((pending & ~grant_oh) | req) : pending;

  // Pending mask, its count, the duplicate-request pulse and the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
      overflow <= 1'b0;
      ptr      <= TOP_IDX;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= popcnt(pend_nxt);
      overflow <= enable & (|(req & pending & ~grant_oh));
      if ((RR == ENC_MODE_RR) && xfer) begin
        ptr <= (out_idx == '0) ? TOP_IDX : (out_idx - 1'b1);
      end
    end
  end

endmodule
